// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the fetch/decode skid buffer
package pipeline_pkg;

  localparam int FD_W = 16;

  // Instruction word presented on the decode side after reset.
  localparam logic [FD_W-1:0] NOP_INSTR = 16'h0000;

  typedef struct packed {
    logic [FD_W-1:0] pc;
    logic [FD_W-1:0] instr;
  } fd_beat_t;

  typedef enum logic [1:0] {
    FD_EMPTY = 2'd0,
    FD_ONE   = 2'd1,
    FD_FULL  = 2'd2
  } fd_state_t;

  // Number of beats held in a given buffer state.
  function automatic logic [1:0] fd_occupancy(input fd_state_t s);
    case (s)
      FD_ONE:  return 2'd1;
      FD_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/en_dff.sv
// rtl/en_dff.sv - W-bit register with load enable and synchronous active-low reset
module en_dff #(
  parameter int           W       = 16,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  // Hold the stored word unless a load is requested.
  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  // Storage flop; reset forces the configured reset value.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_q <= RST_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/fetch_decode_skid.sv
// rtl/fetch_decode_skid.sv - two-entry skid-buffered fetch-to-decode pipeline register
module fetch_decode_skid
  import pipeline_pkg::*;
#(
  parameter int N = FD_W
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         FLUSH,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] IN_PC,
  input  logic [N-1:0] IN_INSTR,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N-1:0] OUT_PC,
  output logic [N-1:0] OUT_INSTR,
  output logic [1:0]   OCCUPANCY
);

  logic      main_valid_d, main_valid_q;
  logic      skid_valid_d, skid_valid_q;
  fd_state_t state;
  fd_state_t state_d;
  logic      in_fire;
  logic      out_fire;
  logic      main_load;
  logic      main_from_skid;
  logic      skid_load;

  logic [N-1:0] main_pc_in;
  logic [N-1:0] main_instr_in;
  logic [N-1:0] skid_pc_q;
  logic [N-1:0] skid_instr_q;

  // Ready comes only from the skid valid flop, so OUT_READY never reaches IN_READY.
  assign IN_READY  = !skid_valid_q;
  assign OUT_VALID = main_valid_q;
  assign in_fire   = IN_VALID & IN_READY;
  assign out_fire  = main_valid_q & OUT_READY;

  // Decode the buffer state from the two slot valid bits.
  always_comb begin
    state = FD_EMPTY;
    if (skid_valid_q) begin
      state = FD_FULL;
    end else if (main_valid_q) begin
      state = FD_ONE;
    end
  end

  assign OCCUPANCY = fd_occupancy(state);

  // Next state and slot load controls; flush discards everything including an offered beat.
  always_comb begin
    state_d        = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (FLUSH) begin
      state_d = FD_EMPTY;
    end else begin
      case (state)
        FD_EMPTY: begin
          if (in_fire) begin
            state_d   = FD_ONE;
            main_load = 1'b1;
          end
        end
        FD_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_d   = FD_FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d = FD_EMPTY;
          end
        end
        FD_FULL: begin
          if (out_fire) begin
            state_d        = FD_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: begin
          state_d = FD_EMPTY;
        end
      endcase
    end
  end

  // Re-encode the next state into the slot valid bits.
  always_comb begin
    main_valid_d = (state_d != FD_EMPTY);
    skid_valid_d = (state_d == FD_FULL);
  end

  // Slot valid registers; reset empties both slots.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Main slot refills from the skid slot when draining a full buffer, else from fetch.
  always_comb begin
    main_pc_in    = IN_PC;
    main_instr_in = IN_INSTR;
    if (main_from_skid) begin
      main_pc_in    = skid_pc_q;
      main_instr_in = skid_instr_q;
    end
  end

  en_dff #(.W(N), .RST_VAL('0)) u_main_pc (
    .clk    (CLOCK),
    .resetn (RESET),
    .en     (main_load),
    .d      (main_pc_in),
    .q      (OUT_PC)
  );

  en_dff #(.W(N), .RST_VAL(N'(NOP_INSTR))) u_main_instr (
    .clk    (CLOCK),
    .resetn (RESET),
    .en     (main_load),
    .d      (main_instr_in),
    .q      (OUT_INSTR)
  );

  en_dff #(.W(N), .RST_VAL('0)) u_skid_pc (
    .clk    (CLOCK),
    .resetn (RESET),
    .en     (skid_load),
    .d      (IN_PC),
    .q      (skid_pc_q)
  );

  en_dff #(.W(N), .RST_VAL('0)) u_skid_instr (
    .clk    (CLOCK),
    .resetn (RESET),
    .en     (skid_load),
    .d      (IN_INSTR),
    .q      (skid_instr_q)
  );

endmodule

// File: tb/tb_fetch_decode_skid.sv
// tb/tb_fetch_decode_skid.sv - scoreboard bench for the fetch/decode skid buffer
module tb_fetch_decode_skid;
  import pipeline_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pc;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [15:0] out_instr;
  logic [1:0]  occupancy;

  fetch_decode_skid #(.N(16)) dut (
    .CLOCK     (clk),
    .RESET     (rst_n),
    .FLUSH     (flush),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_PC     (in_pc),
    .IN_INSTR  (in_instr),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_PC    (out_pc),
    .OUT_INSTR (out_instr),
    .OCCUPANCY (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: beats accepted and not yet consumed, oldest first (at most two).
  fd_beat_t    exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          started = 0;
  bit          after_reset = 0;
  bit          hold_prev = 0;
  logic [15:0] prev_pc;
  logic [15:0] prev_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, then commit the model at the rising edge.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [15:0] pc, input logic [15:0] ins, input logic ordy);
    bit       accept;
    fd_beat_t b;
    rst_n     = r;
    flush     = f;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    accept    = iv && r && !f && (exp_q.size() < 2);
    @(posedge clk);
    if (!r || f) begin
      exp_q.delete();
    end else if (accept) begin
      b.pc    = pc;
      b.instr = ins;
      exp_q.push_back(b);
    end
    if (!r) after_reset = 1;
    else if (accept) after_reset = 0;
    started = 1;
    #1;
  endtask

  // Monitor: compare outputs against the model away from the edge, pop on consumption.
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
      chk("in_ready",  32'(in_ready),  32'(exp_q.size() < 2));
      if (exp_q.size() != 0) begin
        chk("out_pc",    32'(out_pc),    32'(exp_q[0].pc));
        chk("out_instr", 32'(out_instr), 32'(exp_q[0].instr));
      end else if (after_reset) begin
        chk("reset_pc",    32'(out_pc),    32'h0);
        chk("reset_instr", 32'(out_instr), 32'(NOP_INSTR));
      end
      if (hold_prev) begin
        chk("stall_pc",    32'(out_pc),    32'(prev_pc));
        chk("stall_instr", 32'(out_instr), 32'(prev_instr));
      end
      hold_prev  = out_valid && !out_ready && rst_n && !flush;
      prev_pc    = out_pc;
      prev_instr = out_instr;
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
    end
  end

  initial begin
    logic [15:0] rpc;
    rst_n = 0; flush = 0; in_valid = 0; in_pc = '0; in_instr = '0; out_ready = 0;

    // Reset held for two edges.
    step(0, 0, 0, 16'h0000, 16'h0000, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0);
    step(1, 0, 0, 16'h0000, 16'h0000, 1);

    // Back-to-back streaming.
    step(1, 0, 1, 16'h0000, 16'h8C01, 1);
    step(1, 0, 1, 16'h0002, 16'h8C02, 1);
    step(1, 0, 1, 16'h0004, 16'h8C03, 1);
    step(1, 0, 0, 16'h0000, 16'h0000, 1);
    step(1, 0, 0, 16'h0000, 16'h0000, 1);

    // Backpressure: A and B fill the buffer, C waits until space frees up.
    step(1, 0, 1, 16'h0010, 16'h1111, 0);
    step(1, 0, 1, 16'h0012, 16'h2222, 0);
    step(1, 0, 1, 16'h0014, 16'h3333, 0);
    step(1, 0, 1, 16'h0014, 16'h3333, 0);
    step(1, 0, 1, 16'h0014, 16'h3333, 1);
    step(1, 0, 1, 16'h0014, 16'h3333, 1);
    step(1, 0, 0, 16'h0000, 16'h0000, 1);
    step(1, 0, 0, 16'h0000, 16'h0000, 1);

    // Flush while full with a beat offered.
    step(1, 0, 1, 16'h0016, 16'h6666, 0);
    step(1, 0, 1, 16'h0018, 16'h7777, 0);
    step(1, 1, 1, 16'h0020, 16'h4444, 0);
    step(1, 0, 0, 16'h0000, 16'h0000, 1);
    step(1, 0, 0, 16'h0000, 16'h0000, 1);

    // Reset while full, then a single beat.
    step(1, 0, 1, 16'h0022, 16'h8888, 0);
    step(1, 0, 1, 16'h0024, 16'h9999, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0);
    step(1, 0, 1, 16'h0030, 16'h5555, 1);
    step(1, 0, 0, 16'h0000, 16'h0000, 1);

    // Randomized traffic with occasional flush and reset.
    rpc = 16'h1000;
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 7),
           rpc,
           16'($urandom),
           ($urandom_range(0, 9) < 6));
      rpc = rpc + 16'd2;
    end

    // Drain.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 16'h0000, 16'h0000, 1);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
